// File: rtl/syndrome_locator.sv
// syndrome_locator: two-stage elastic front end of the 14-bit Hamming decoder.
// Stage 1 captures the received word with its syndrome; stage 2 turns the
// syndrome into a one-hot error pattern for the downstream XOR corrector.
// Saturating counters tally delivered correctable and uncorrectable words.
// CW must be 14 and SW must be 4 for the position numbering to hold.
module syndrome_locator #(
  parameter int CW    = 14,
  parameter int SW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_code,
  output logic [CW-1:0]    out_err,
  output logic [SW-1:0]    out_syn,
  output logic             out_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Stage 1 holding register
  logic             r_s1_valid;
  logic [CW-1:0]    r_s1_code;
  logic [SW-1:0]    r_s1_syn;

  // Stage 2 holding register, which drives the outputs directly
  logic             r_s2_valid;
  logic [CW-1:0]    r_out_code;
  logic [CW-1:0]    r_out_err;
  logic [SW-1:0]    r_out_syn;
  logic             r_out_uncorr;

  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic [SW-1:0]    w_syn;
  logic [CW-1:0]    w_dec_err;
  logic             w_dec_uncorr;
  logic             w_adv2;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_corr_hit;

  // Syndrome: XOR of the 1-based positions of every set bit
  always_comb begin
    w_syn = '0;
    for (int k = 0; k < CW; k++) begin
      if (in_code[k]) begin
        w_syn = w_syn ^ SW'(k + 1);
      end
    end
  end

  // One-hot decode of the stage-1 syndrome; value 15 matches no bit and
  // therefore yields an all-zero pattern instead of a miscorrection
  genvar gi;
  generate
    for (gi = 0; gi < CW; gi++) begin : g_dec
      assign w_dec_err[gi] = (r_s1_syn == SW'(gi + 1));
    end
  endgenerate

  assign w_dec_uncorr = (r_s1_syn == {SW{1'b1}});

  // Handshake: in_ready depends on out_ready but never on in_valid
  assign w_adv2     = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_adv2;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;
  assign w_corr_hit = (r_out_syn != '0) && !r_out_uncorr;

  // Stage 1: load on input transfer, empty when its word moves on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_code  <= in_code;
      r_s1_syn   <= w_syn;
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: take the decoded word on advance, empty on output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_out_code   <= '0;
      r_out_err    <= '0;
      r_out_syn    <= '0;
      r_out_uncorr <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid   <= 1'b1;
      r_out_code   <= r_s1_code;
      r_out_err    <= w_dec_err;
      r_out_syn    <= r_s1_syn;
      r_out_uncorr <= w_dec_uncorr;
    end else if (w_out_xfer) begin
      r_s2_valid   <= 1'b0;
    end
  end

  // Saturating counters; clear wins over a same-cycle delivery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_xfer) begin
      if (w_corr_hit && (r_corr_cnt != {CNT_W{1'b1}})) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (r_out_uncorr && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_code   = r_out_code;
  assign out_err    = r_out_err;
  assign out_syn    = r_out_syn;
  assign out_uncorr = r_out_uncorr;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_syndrome_locator.sv
// Bench for syndrome_locator: directed scenarios plus a random traffic phase,
// scored against a queue-based reference of the decoder's rules.
module tb_syndrome_locator;
  localparam int CW    = 14;
  localparam int SW    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_code;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_code;
  logic [CW-1:0]    out_err;
  logic [SW-1:0]    out_syn;
  logic             out_uncorr;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] sb[$];
  int m_corr = 0;
  int m_uncorr = 0;

  syndrome_locator #(.CW(CW), .SW(SW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_err(out_err), .out_syn(out_syn),
    .out_uncorr(out_uncorr), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference syndrome: XOR of 1-based positions of the set bits
  function automatic int ref_syn(input logic [CW-1:0] c);
    int s = 0;
    for (int k = 0; k < CW; k++) if (c[k]) s = s ^ (k + 1);
    return s;
  endfunction

  // Reference pattern: the single bit whose position equals the syndrome
  function automatic logic [CW-1:0] ref_err(input logic [CW-1:0] c);
    logic [CW-1:0] e = '0;
    int s = ref_syn(c);
    for (int p = 1; p <= CW; p++) if (p == s) e[p-1] = 1'b1;
    return e;
  endfunction

  // One clock: score the handshake seen before the edge, then the counters after it
  task automatic tick();
    logic [CW-1:0] c;
    logic out_x;
    int s;
    #1;
    out_x = out_valid && out_ready;
    if (out_x) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'(0));
      end else begin
        c = sb.pop_front();
        s = ref_syn(c);
        check("out_code", 32'(out_code), 32'(c));
        check("out_syn", 32'(out_syn), 32'(s));
        check("out_err", 32'(out_err), 32'(ref_err(c)));
        check("out_uncorr", 32'(out_uncorr), 32'(s == 15));
        if (!cnt_clr) begin
          if (s >= 1 && s <= 14 && m_corr < CMAX) m_corr++;
          if (s == 15 && m_uncorr < CMAX) m_uncorr++;
        end
      end
    end
    if (cnt_clr) begin
      m_corr = 0;
      m_uncorr = 0;
    end
    if (in_valid && in_ready) sb.push_back(in_code);
    @(negedge clk);
    check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
    check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
  endtask

  // Send one word with out_ready high and verify the two-cycle latency
  task automatic send_latency(input logic [CW-1:0] c, input string tag);
    in_code = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 check({tag, "_not_early"}, 32'(out_valid), 32'(0));
    tick();
    #1 check({tag, "_valid_at_2"}, 32'(out_valid), 32'(1));
  endtask

  initial begin
    logic [CW-1:0] hold_code;
    logic [SW-1:0] hold_syn;
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_code", 32'(out_code), 32'(0));
    check("rst_out_err", 32'(out_err), 32'(0));
    check("rst_out_syn", 32'(out_syn), 32'(0));
    check("rst_out_uncorr", 32'(out_uncorr), 32'(0));
    check("rst_corr_cnt", 32'(corr_cnt), 32'(0));
    check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // T1: clean word
    send_latency(14'h0000, "t1");
    tick();
    check("t1_corr_unchanged", 32'(corr_cnt), 32'(0));

    // T2: single error at position 5
    send_latency(14'h0010, "t2");
    check("t2_corrected", 32'(out_code ^ out_err), 32'(0));
    tick();
    check("t2_corr_cnt", 32'(corr_cnt), 32'(1));

    // T3: parity bits only -> syndrome 15
    send_latency(14'h008B, "t3");
    check("t3_uncorr_flag", 32'(out_uncorr), 32'(1));
    tick();
    check("t3_uncorr_cnt", 32'(uncorr_cnt), 32'(1));

    // T4: stall with three back-to-back words
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_code = 14'h0001; tick();
    in_code = 14'h0100; tick();
    in_code = 14'h2000;
    #1 check("t4_in_ready_3rd", 32'(in_ready), 32'(0));
    hold_code = out_code;
    hold_syn = out_syn;
    tick();
    tick();
    #1 check("t4_stall_in_ready", 32'(in_ready), 32'(0));
    check("t4_stable_code", 32'(out_code), 32'(hold_code));
    check("t4_stable_syn", 32'(out_syn), 32'(hold_syn));
    out_ready = 1'b1;
    #1 check("t4_release_valid0", 32'(out_valid), 32'(1));
    tick();
    in_valid = 1'b0;
    #1 check("t4_release_valid1", 32'(out_valid), 32'(1));
    tick();
    #1 check("t4_release_valid2", 32'(out_valid), 32'(1));
    tick();
    check("t4_all_delivered", 32'(sb.size()), 32'(0));

    // T5: saturation at 15, then clear coincident with a transfer
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_code = 14'h0001 << $urandom_range(13, 0);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t5_saturated", 32'(corr_cnt), 32'(CMAX));
    in_code = 14'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1 check("t5_xfer_pending", 32'(out_valid), 32'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t5_cleared", 32'(corr_cnt), 32'(0));

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(1, 0));
      in_code = 14'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      cnt_clr = ($urandom_range(40, 0) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rand_drained", 32'(sb.size()), 32'(0));

    // T6: reset with two words in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_code = 14'h0004; tick();
    in_code = 14'h008B; tick();
    in_valid = 1'b0;
    #1 check("t6_pre_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_corr_cnt", 32'(corr_cnt), 32'(0));
    check("t6_uncorr_cnt", 32'(uncorr_cnt), 32'(0));
    sb.delete();
    m_corr = 0;
    m_uncorr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_latency(14'h0040, "t6");
    tick();
    check("t6_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
